param_stream_sink: RTL and testbench
====================================

Name: param_stream_sink

Overview:
- Receiving end of the parameter-source valid/ready stream. Accepts one tensor's worth of parameter beats (e.g. a bias vector) and stores them in an internal RAM.
- Once loading completes, exposes the stored tensor through an addressed read port. The read port has the same 2-cycle registered latency as the parameter ROMs.
- Used to capture parameters streamed in from off-chip or from another layer, instead of baking them into a ROM.

Parameters:
- TENSOR_SIZE_DIM_0, 32, tensor elements along dim 0.
- TENSOR_SIZE_DIM_1, 1, tensor elements along dim 1.
- PRECISION_0, 16, element total width in bits.
- PRECISION_1, 3, element fractional bits (metadata only, no arithmetic).
- PARALLELISM_DIM_0, 1, elements per beat along dim 0.
- PARALLELISM_DIM_1, 1, elements per beat along dim 1.
- IN_DEPTH, (TENSOR_SIZE_DIM_0*TENSOR_SIZE_DIM_1)/(PARALLELISM_DIM_0*PARALLELISM_DIM_1), beats per tensor and RAM depth.
- ADDR_WIDTH, $clog2(IN_DEPTH)+1, counter and read-address width; one extra bit so IN_DEPTH itself fits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- data_in  in  [PRECISION_0-1:0] x (PARALLELISM_DIM_0*PARALLELISM_DIM_1)  beat elements, unpacked array, element j packed at bits [PRECISION_0*j +: PRECISION_0] of the RAM word.
- data_in_valid  in  1  beat valid.
- data_in_ready  out  1  sink accepts a beat.
- load_start  in  1  single-cycle pulse that starts a new load.
- loaded  out  1  full tensor stored and readable.
- load_count  out  ADDR_WIDTH  beats accepted in the current load.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read beat index.
- rd_data  out  [PRECISION_0-1:0] x (PARALLELISM_DIM_0*PARALLELISM_DIM_1)  read beat.
- rd_valid  out  1  rd_data valid.

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE, load_count=0, loaded=0, data_in_ready=0, rd_valid=0, both read pipeline stages and rd_data=0. RAM contents are not reset.
- States and transitions:
  - IDLE: load_start -> LOAD.
  - LOAD: final accepted beat -> DONE.
  - DONE: load_start -> LOAD.
  - load_start received while in LOAD is ignored.
- Entering LOAD: load_count<=0 and loaded<=0 on the same edge.
- data_in_ready is 1 only in LOAD. It is registered, decoded from the state register, with no combinational path from data_in_valid.
- Transfer occurs when data_in_valid && data_in_ready. Each transfer writes the beat to RAM[load_count] and increments load_count.
- When the transfer happens with load_count==IN_DEPTH-1:
  - load_count becomes IN_DEPTH.
  - state becomes DONE.
  - loaded<=1 on that edge, so loaded is visible the next cycle.
  - data_in_ready drops the next cycle; no extra beat is accepted.
- Valid may stall at any time. Gaps do not affect the count.
- Beats presented while not in LOAD are not accepted and do not write RAM.
- Read port:
  - rd_en samples rd_addr at cycle T. rd_data and rd_valid appear at T+2.
  - Back-to-back reads are accepted every cycle, fully pipelined.
  - The read pipeline always advances; there is no backpressure on the read side.
  - rd_valid(T+2) = rd_en(T) && loaded(T) && rd_addr(T)<IN_DEPTH.
  - When rd_valid=0, rd_data=0. This covers out-of-range addresses, reads issued while not loaded, and idle cycles.
  - A read issued in the same cycle that load_start is accepted sees loaded=1 and returns old RAM data with rd_valid=1.
- Reset asserted mid-load: returns to IDLE immediately. A partial load is discarded (loaded=0) and requires a new load_start.
- Simultaneous load_start and final beat in LOAD: the beat completes, go to DONE, load_start is ignored.

Decomposition:
- Shared package param_stream_pkg holds:
  - state enum (IDLE, LOAD, DONE), 2 bits;
  - a localparam function computing IN_DEPTH from sizes and parallelism.
- One sub-module: param_sink_ram. It is a simple dual-port RAM:
  - one synchronous write port;
  - one read port with 2 registered stages (both enabled always);
  - word width PRECISION_0*PARALLELISM_DIM_0*PARALLELISM_DIM_1, depth IN_DEPTH.
- Top level holds the FSM, the counter, the valid/range pipeline, the output zero-gating, and packing/unpacking between the array and the word.

Test Plan:
- Reset, then load_start, then 32 beats of data 0x0000..0x001F with valid held high. Expect:
  - data_in_ready=1 for exactly 32 accepted cycles;
  - load_count=32;
  - loaded=1 the cycle after the last beat, then data_in_ready=0.
- After the load, read addr 0, 5, 31 on consecutive cycles. Expect rd_valid=1 and rd_data 0x0000, 0x0005, 0x001F at T+2, T+3, T+4.
- Valid toggling 1/0 randomly during a load of 0xA000+i. Expect exactly 32 writes and readback 0xA000+i for all i.
- Read addr 32 and addr 40 when loaded. Expect rd_valid=0 and rd_data=0 at T+2. A read before any load gives rd_valid=0.
- Assert rst low after 10 beats. Expect:
  - loaded=0, load_count=0, data_in_ready=0 asynchronously;
  - a subsequent full load of new data reads back correctly.
- Reload in DONE with data 0x1000+i. Expect:
  - loaded=0 the cycle after load_start;
  - a load_start pulse during LOAD is ignored (count continues);
  - final readback is 0x1000+i.

Source files
------------

// File: rtl/param_stream_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// param_stream_pkg : shared types and depth helper for the parameter stream sink
// Revision 1.0
// ----------------------------------------------------------------------------
package param_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int calc_in_depth(input int size0, input int size1,
                                         input int par0,  input int par1);
        return (size0 * size1) / (par0 * par1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_sink_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// param_sink_ram : simple dual-port RAM, synchronous write, 2-stage registered read
// Revision 1.0
// ----------------------------------------------------------------------------
module param_sink_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Storage is not reset; only the read pipeline is cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= mem_q[raddr_i];
            stage2_q <= stage1_q;
        end
    end

    assign rdata_o = stage2_q;

endmodule
`default_nettype wire

// File: rtl/param_stream_sink.sv
`default_nettype none
// ----------------------------------------------------------------------------
// param_stream_sink : captures one streamed tensor into RAM, then serves addressed reads
// Revision 1.0
// ----------------------------------------------------------------------------
module param_stream_sink
    import param_stream_pkg::*;
#(
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int TENSOR_SIZE_DIM_1 = 1,
    parameter int PRECISION_0       = 16,
    parameter int PRECISION_1       = 3,
    parameter int PARALLELISM_DIM_0 = 1,
    parameter int PARALLELISM_DIM_1 = 1,
    parameter int IN_DEPTH   = calc_in_depth(TENSOR_SIZE_DIM_0, TENSOR_SIZE_DIM_1,
                                             PARALLELISM_DIM_0, PARALLELISM_DIM_1),
    parameter int ADDR_WIDTH = $clog2(IN_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PRECISION_0-1:0] data_in [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    input  logic                   load_start,
    output logic                   loaded,
    output logic [ADDR_WIDTH-1:0]  load_count,
    input  logic                   rd_en,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [PRECISION_0-1:0] rd_data [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
    output logic                   rd_valid
);

    localparam int NPAR   = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
    localparam int WORD_W = PRECISION_0 * NPAR;
    localparam int RAM_AW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] C_LAST  = ADDR_WIDTH'(IN_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] C_DEPTH = ADDR_WIDTH'(IN_DEPTH);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   load_count_q;
    logic                    loaded_q;
    logic                    ready_q;
    logic                    rd_ok_d;
    logic                    rd_valid1_q;
    logic                    rd_valid2_q;
    logic                    xfer;
    logic [WORD_W-1:0]       wr_word;
    logic [WORD_W-1:0]       rd_word;

    assign xfer = data_in_valid && ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            load_count_q <= '0;
            loaded_q     <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (load_start) begin
                        state_q      <= ST_LOAD;
                        load_count_q <= '0;
                        loaded_q     <= 1'b0;
                        ready_q      <= 1'b1;
                    end
                end
                // load_start is deliberately not looked at while loading.
                ST_LOAD: begin
                    if (xfer) begin
                        load_count_q <= load_count_q + ADDR_WIDTH'(1);
                        if (load_count_q == C_LAST) begin
                            state_q  <= ST_DONE;
                            loaded_q <= 1'b1;
                            ready_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_ok_d = rd_en && loaded_q && (rd_addr < C_DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid1_q <= 1'b0;
            rd_valid2_q <= 1'b0;
        end else begin
            rd_valid1_q <= rd_ok_d;
            rd_valid2_q <= rd_valid1_q;
        end
    end

    param_sink_ram #(
        .WIDTH (WORD_W),
        .DEPTH (IN_DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (xfer),
        .waddr_i (load_count_q[RAM_AW-1:0]),
        .wdata_i (wr_word),
        .raddr_i (rd_addr[RAM_AW-1:0]),
        .rdata_o (rd_word)
    );

    for (genvar j = 0; j < NPAR; j++) begin : g_pack
        assign wr_word[PRECISION_0*j +: PRECISION_0] = data_in[j];
        assign rd_data[j] = rd_valid2_q ? rd_word[PRECISION_0*j +: PRECISION_0] : '0;
    end

    assign data_in_ready = ready_q;
    assign loaded        = loaded_q;
    assign load_count    = load_count_q;
    assign rd_valid      = rd_valid2_q;

endmodule
`default_nettype wire

// File: tb/tb_param_stream_sink.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_param_stream_sink : randomized load/readback bench with scoreboard monitor
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_param_stream_sink;

    localparam int DEPTH = 32;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   data_in [1];
    logic          data_in_valid;
    logic          data_in_ready;
    logic          load_start;
    logic          loaded;
    logic [AW-1:0] load_count;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data [1];
    logic          rd_valid;

    param_stream_sink dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .load_start    (load_start),
        .loaded        (loaded),
        .load_count    (load_count),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          v;
        logic [15:0] d;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_mem [DEPTH];
    bit          model_loaded = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-side monitor: compares whatever the DUT presents against the queue.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL read_missed: due=%0d now=%0d", e.due, cyc);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            if (rd_valid !== e.v || rd_data[0] !== e.d) begin
                errors++;
                $display("FAIL read_cyc%0d: got valid=%b data=%h, want valid=%b data=%h",
                         cyc, rd_valid, rd_data[0], e.v, e.d);
            end
        end else if (rd_valid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL read_unexpected: got valid=%b data=%h at cyc %0d, want valid=0",
                     rd_valid, rd_data[0], cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Expected read response is computed from the model state at issue time.
    task automatic push_read(input int addr);
        exp_t e;
        e.due = cyc + 2;
        e.v   = model_loaded && (addr < DEPTH);
        e.d   = e.v ? model_mem[addr] : 16'h0000;
        sb.push_back(e);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
    endtask

    task automatic issue_reads(input int addrs[$]);
        foreach (addrs[k]) begin
            push_read(addrs[k]);
            @(posedge clk); #1;
        end
        rd_en = 1'b0;
    endtask

    task automatic readback_all();
        int addrs[$];
        for (int a = 0; a < DEPTH; a++) addrs.push_back(a);
        issue_reads(addrs);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        push_read(3);
        @(posedge clk); #1;
        load_start   = 1'b0;
        rd_en        = 1'b0;
        model_loaded = 1'b0;
        chk("start_loaded", {31'd0, loaded}, 0);
        chk("start_count", {26'd0, load_count}, 0);
        chk("start_ready", {31'd0, data_in_ready}, 1);
    endtask

    // Presents beats base+i until nbeats are accepted; acceptance is predicted, not observed.
    task automatic feed(input logic [15:0] base, input int nbeats, input bit rnd, input bit glitch);
        int i = 0;
        int guard = 0;
        while (i < nbeats && guard < 1000) begin
            data_in[0]    = base + 16'(i);
            data_in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            load_start    = glitch && (i == 10 || i == DEPTH - 1);
            chk("ready_in_load", {31'd0, data_in_ready}, 1);
            @(posedge clk); #1;
            if (data_in_valid) begin
                model_mem[i] = base + 16'(i);
                i++;
            end
            chk("count_step", {26'd0, load_count}, i);
            guard++;
        end
        load_start    = 1'b0;
        data_in_valid = 1'b0;
    endtask

    task automatic full_load(input logic [15:0] base, input bit rnd, input bit glitch);
        start_load();
        feed(base, DEPTH, rnd, glitch);
        model_loaded = 1'b1;
        chk("done_loaded", {31'd0, loaded}, 1);
        chk("done_ready", {31'd0, data_in_ready}, 0);
        chk("done_count", {26'd0, load_count}, DEPTH);
        data_in[0]    = 16'hDEAD;
        data_in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        chk("post_ready", {31'd0, data_in_ready}, 0);
        chk("post_count", {26'd0, load_count}, DEPTH);
        chk("post_loaded", {31'd0, loaded}, 1);
    endtask

    initial begin
        int addrs[$];
        rst           = 1'b0;
        data_in[0]    = '0;
        data_in_valid = 1'b0;
        load_start    = 1'b0;
        rd_en         = 1'b0;
        rd_addr       = '0;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, data_in_ready}, 0);
        chk("rst_loaded", {31'd0, loaded}, 0);
        chk("rst_count", {26'd0, load_count}, 0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 0);
        chk("rst_rd_data", {16'd0, rd_data[0]}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        addrs = '{0};
        issue_reads(addrs);
        drain();

        full_load(16'h0000, 1'b0, 1'b0);
        addrs = '{0, 5, 31};
        issue_reads(addrs);
        drain();
        addrs = '{32, 40, 63};
        issue_reads(addrs);
        drain();

        full_load(16'hA000, 1'b1, 1'b0);
        readback_all();
        drain();

        start_load();
        feed(16'h5500, 10, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_loaded", {31'd0, loaded}, 0);
        chk("arst_count", {26'd0, load_count}, 0);
        chk("arst_ready", {31'd0, data_in_ready}, 0);
        sb.delete();
        model_loaded = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("arst_idle_ready", {31'd0, data_in_ready}, 0);
        addrs = '{0, 9};
        issue_reads(addrs);
        drain();
        full_load(16'h7700, 1'b1, 1'b0);
        readback_all();
        drain();

        full_load(16'h1000, 1'b1, 1'b1);
        readback_all();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
